// File: rtl/conv_out_wb.sv
// Convolution output writeback: shift, ReLU, saturate to int8,
// pack four lanes per word and write them to memory via a 2-entry FIFO.
module conv_out_wb #(
    parameter int         N_OUT    = 128,
    parameter logic [7:0] OUT_BASE = 8'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        relu_en,
    input  logic [4:0]  cfg_shift,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    output logic        res_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam int CW = $clog2(N_OUT) + 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    lane_q, lane_d;
    logic [7:0]    widx_q, widx_d;
    logic [23:0]   stage_q, stage_d;
    logic [31:0]   fifo_q [2];
    logic [31:0]   fifo_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    occ_q, occ_d;

    logic signed [31:0] shifted;
    logic [7:0]         res_byte;
    logic               accept;
    logic               push;
    logic               pop;

    assign res_ready = (state_q == RUN) && (occ_q != 2'd2);
    assign accept    = res_valid && res_ready;
    assign push      = accept && (lane_q == 2'd3);
    assign mem_req   = (occ_q != 2'd0);
    assign mem_we    = mem_req;
    assign pop       = mem_req && mem_gnt;
    assign mem_addr  = OUT_BASE + widx_q;
    assign mem_wdata = mem_req ? fifo_q[rd_ptr_q] : 32'h0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    // Condition one result: arithmetic shift, optional ReLU, clamp to int8
    always_comb begin
        shifted = $signed(res_data) >>> cfg_shift;
        if (relu_en && shifted < 0) begin
            shifted = '0;
        end
        if (shifted > 32'sd127) begin
            res_byte = 8'h7f;
        end else if (shifted < -32'sd128) begin
            res_byte = 8'h80;
        end else begin
            res_byte = shifted[7:0];
        end
    end

    // Next-state, lane packing, FIFO bookkeeping and word index
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        widx_d   = widx_q;
        stage_d  = stage_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (accept) begin
            cnt_d  = cnt_q + 1'b1;
            lane_d = lane_q + 2'd1;
            unique case (lane_q)
                2'd0: stage_d[7:0]   = res_byte;
                2'd1: stage_d[15:8]  = res_byte;
                2'd2: stage_d[23:16] = res_byte;
                default: ;
            endcase
        end
        if (push) begin
            fifo_d[wr_ptr_q] = {res_byte, stage_q};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            widx_d   = widx_q + 8'd1;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    lane_d  = '0;
                    widx_d  = '0;
                    stage_d = '0;
                end
            end
            RUN: begin
                if (accept && cnt_q == CW'(N_OUT - 1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (occ_d == 2'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lane_q    <= '0;
            widx_q    <= '0;
            stage_q   <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            widx_q    <= widx_d;
            stage_q   <= stage_d;
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
        end
    end

endmodule

// File: doc/conv_out_wb.md
CONV_OUT_WB -- requirements
Module: conv_out_wb

Interface
REQ-001 SHALL have parameter N_OUT, default 128; number of results per frame, multiple of 4.
REQ-002 SHALL have parameter OUT_BASE, default 8'd64; memory word address of the first output word.
REQ-003 Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse that opens a new output frame.
REQ-007 relu_en  in  1  clamps negative results to 0.
REQ-008 cfg_shift  in  5  arithmetic right-shift amount applied to each result.
REQ-009 res_valid  in  1  convolution result present on res_data.
REQ-010 res_data  in  32  signed convolution sum from the datapath.
REQ-011 res_ready  out  1  block accepts res_data this cycle.
REQ-012 mem_req  out  1  write request to data memory.
REQ-013 mem_we  out  1  write enable; equals mem_req.
REQ-014 mem_addr  out  8  word address of the current write.
REQ-015 mem_wdata  out  32  four packed 8-bit results.
REQ-016 mem_gnt  in  1  memory accepted the request this cycle.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at frame completion.

Function
REQ-019 SHALL implement FSM IDLE, RUN, FLUSH, DONE; start in IDLE -> RUN; start outside IDLE ignored.
REQ-020 On IDLE->RUN SHALL clear the result counter, lane index, word index and staging word.
REQ-021 Result accepted iff res_valid and res_ready on the same rising edge; res_ready = (state==RUN) and (FIFO occupancy < 2).
REQ-022 Per accepted result: y = res_data >>> cfg_shift (sign-preserving); if relu_en and y<0 then y=0; saturate y to [-128,127]; keep the 8-bit two's-complement value.
REQ-023 Accepted result k SHALL go to byte lane k mod 4 of the staging word, lane 0 = bits 7:0.
REQ-024 On acceptance into lane 3, the completed word SHALL be pushed into a 2-entry write FIFO in the same cycle.
REQ-025 After the N_OUT-th acceptance: RUN -> FLUSH; res_ready low from the next cycle.
REQ-026 mem_req SHALL be high whenever the FIFO is non-empty; mem_wdata = FIFO head; mem_addr = OUT_BASE + word index.
REQ-027 mem_addr and mem_wdata SHALL hold stable while mem_req is high and mem_gnt is low.
REQ-028 On mem_req and mem_gnt: pop the FIFO and increment word index, modulo 256 on the 8-bit address.
REQ-029 The next word MAY be presented the cycle after a grant; mem_req may stay high across back-to-back grants.
REQ-030 Push and pop in the same cycle SHALL leave occupancy unchanged; with FIFO full, push cannot occur because res_ready=0.
REQ-031 FLUSH -> DONE when the FIFO is empty; DONE asserts done for exactly one cycle, then -> IDLE.
REQ-032 mem_gnt while mem_req=0 SHALL be ignored.
REQ-033 Latency: the word containing result 4m+3 SHALL request memory on the cycle after its acceptance.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, FIFO empty, all counters and staging word 0.
REQ-035 Reset values: res_ready=0, mem_req=0, mem_we=0, mem_addr=OUT_BASE, mem_wdata=0, busy=0, done=0.
REQ-036 Reset mid-frame SHALL discard partial words and pending writes; no write after rst_n deasserts until a new start.

Verification
REQ-037 Basic frame: defaults, relu_en=0, cfg_shift=0, mem_gnt tied 1, results 0..127 back-to-back -> 32 writes, addr 64..95, first wdata 32'h03020100, done one cycle after last grant.
REQ-038 Arithmetic: cfg_shift=4, res_data = 32'hFFFFFF00, 32'h00000800, 32'h00000123, 32'hFFFF0000, relu_en=0 -> wdata 32'h80127FF0; same with relu_en=1 -> 32'h00127F00.
REQ-039 Backpressure: mem_gnt held 0 for 20 cycles mid-frame -> FIFO fills, res_ready drops after 2 pending words, addr/wdata stable; on release no word lost or duplicated.
REQ-040 Random mem_gnt and res_valid at 50% -> every word is written exactly once, in address order, matching the reference model.
REQ-041 Reset mid-frame after 50 results, then start with 128 new results -> writes restart at addr 64, contents from the new frame only.
REQ-042 start pulses during RUN and FLUSH -> ignored, no counter clears, single done.
